// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a built-in clear engine that fills memory with CLR_VAL
// after reset or on a clr request, and has a registered read path with an rvalid strobe.
module ram_sp_clr #(
  parameter int unsigned   DW      = 8,
  parameter int unsigned   AW      = 10,
  parameter int unsigned   RD_LAT  = 1,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic          rvalid,
  output logic          busy
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_clr_wr;
  logic          w_acc;
  logic          w_uwr;
  logic          w_urd;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

  // rst and clr both pre-empt the clear write and any user request on their edge
  always_comb begin
    w_clr_wr = (r_state == S_CLEAR) && !rst && !clr;
    w_acc    = (r_state == S_IDLE) && !rst && !clr && en;
    w_uwr    = w_acc && rw;
    w_urd    = w_acc && !rw;
    w_we     = w_clr_wr || w_uwr;
    w_waddr  = w_clr_wr ? r_ptr : addr;
    w_wdata  = w_clr_wr ? CLR_VAL : din;
    w_rdata  = r_mem[addr];
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == '1) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign busy = r_busy;

  // Any RD_LAT other than 1 builds the two-stage path
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          dout   <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= w_urd;
          if (w_urd) dout <= w_rdata;
        end
      end
    end else begin : g_lat2
      logic [DW-1:0] r_p1_data;
      logic          r_p1_vld;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_p1_data <= '0;
          r_p1_vld  <= 1'b0;
          dout      <= '0;
          rvalid    <= 1'b0;
        end else begin
          r_p1_vld <= w_urd;
          if (w_urd) r_p1_data <= w_rdata;
          rvalid <= r_p1_vld;
          if (r_p1_vld) dout <= r_p1_data;
        end
      end
    end
  endgenerate

endmodule
